// File: rtl/throw_traj_ctl_if.sv
// rtl/throw_traj_ctl_if.sv - game FSM <-> throw controller signal bundle
// master: game FSM side (drives enable, throw_force, wind_force)
// slave:  throw controller side (drives position, status and outcome)
interface throw_traj_ctl_if;
  logic               enable;
  logic [9:0]         throw_force;
  logic [6:0]         wind_force;
  logic signed [11:0] x_pos;
  logic signed [11:0] y_pos;
  logic               busy;
  logic               hit_target;
  logic               hit_wall;
  logic [1:0]         outcome;
  logic               throw_done;

  modport master (
    output enable, throw_force, wind_force,
    input  x_pos, y_pos, busy, hit_target, hit_wall, outcome, throw_done
  );

  modport slave (
    input  enable, throw_force, wind_force,
    output x_pos, y_pos, busy, hit_target, hit_wall, outcome, throw_done
  );
endinterface

// File: rtl/throw_traj_ctl.sv
// rtl/throw_traj_ctl.sv - parametrised throw-phase projectile controller
// clk  : system clock
// rst  : asynchronous active-high reset
// ctl  : throw_traj_ctl_if.slave
//        in  enable (level throw request), throw_force[9:0], wind_force[6:0] (50 = calm)
//        out x_pos/y_pos (signed world position), busy, hit_target/hit_wall (one-cycle),
//            outcome[1:0] (0 none, 1 target, 2 wall, 3 floor/out), throw_done
module throw_traj_ctl #(
  parameter int TICK_DIV    = 1_300_000,
  parameter int START_X     = 140,
  parameter int START_Y     = 350,
  parameter int DIR         = 1,
  parameter int V0          = 27,
  parameter int GRAVITY     = 1,
  parameter int FORCE_GAIN  = 18,
  parameter int FORCE_SHIFT = 6,
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int TGT_XL      = 867,
  parameter int TGT_XR      = 1024,
  parameter int TGT_YT      = 427,
  parameter int TGT_YB      = 525,
  parameter int WALL_XL     = 490,
  parameter int WALL_XR     = 534,
  parameter int WALL_TOP    = 241,
  parameter int WALL_MARGIN = 15,
  parameter int FLOOR_Y     = 190
) (
  input  logic            clk,
  input  logic            rst,
  throw_traj_ctl_if.slave ctl
);

  typedef enum logic [1:0] {S_IDLE, S_ASCEND, S_DESCEND, S_RESULT} state_t;

  localparam int              CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic signed [11:0] SX = 12'(START_X);
  localparam logic signed [11:0] SY = 12'(START_Y);

  // All window limits live in the 14-bit signed arithmetic domain.
  localparam logic signed [13:0] SCR_W   = 14'(SCREEN_W);
  localparam logic signed [13:0] SCR_H   = 14'(SCREEN_H);
  localparam logic signed [13:0] T_XL    = 14'(TGT_XL);
  localparam logic signed [13:0] T_XR    = 14'(TGT_XR);
  localparam logic signed [13:0] T_YT    = 14'(TGT_YT);
  localparam logic signed [13:0] T_YB    = 14'(TGT_YB);
  localparam logic signed [13:0] W_XL    = 14'(WALL_XL - WALL_MARGIN);
  localparam logic signed [13:0] W_XR    = 14'(WALL_XR + WALL_MARGIN);
  localparam logic signed [13:0] W_Y     = 14'(WALL_TOP - WALL_MARGIN);
  localparam logic signed [13:0] FLOOR   = 14'(FLOOR_Y);
  localparam logic signed [13:0] GRAV    = 14'(GRAVITY);
  localparam logic signed [13:0] VY_INIT = 14'(V0);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [11:0] x_q, x_d, y_q, y_d;
  logic signed [13:0] vx_q, vx_d, vy_q, vy_d;
  logic [1:0]         outcome_q, outcome_d;
  logic               hit_target_q, hit_target_d;
  logic               hit_wall_q, hit_wall_d;

  logic [31:0]        force_prod;
  logic [13:0]        vx_force;
  logic signed [13:0] vx_dir;
  logic [6:0]         wind_delta;
  logic [13:0]        wind_mag;
  logic signed [13:0] wind_eff;
  logic signed [13:0] vx_launch;

  logic               tick;
  logic signed [13:0] nx_raw, ny_raw, nx_e, ny_e, screen_y, vy_next;
  logic signed [11:0] nx, ny;
  logic               in_tgt, in_wall, in_floor;

  function automatic logic signed [11:0] clamp12(input logic signed [13:0] v);
    logic signed [11:0] r;
    if (v > 14'sd2047)       r = 12'sh7ff;
    else if (v < -14'sd2048) r = 12'sh800;
    else                     r = v[11:0];
    return r;
  endfunction

  // Launch velocity: the only multiply, evaluated once per throw.
  always_comb begin
    force_prod = 32'(ctl.throw_force) * 32'(FORCE_GAIN);
    vx_force   = 14'(force_prod >> FORCE_SHIFT);
    vx_dir     = (DIR < 0) ? -$signed(vx_force) : $signed(vx_force);
    // Wind pushes toward calm from either side and ignores DIR.
    wind_delta = (ctl.wind_force > 7'd50) ? (ctl.wind_force - 7'd50) : (7'd50 - ctl.wind_force);
    wind_mag   = 14'd5 + {7'd0, wind_delta >> 3};
    if (ctl.wind_force == 7'd50)     wind_eff = 14'sd0;
    else if (ctl.wind_force > 7'd50) wind_eff = -$signed(wind_mag);
    else                             wind_eff = $signed(wind_mag);
    vx_launch  = vx_dir + wind_eff;
  end

  // Next position and hit windows, all evaluated on the post-tick position.
  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    nx_raw   = $signed({{2{x_q[11]}}, x_q}) + vx_q;
    ny_raw   = $signed({{2{y_q[11]}}, y_q}) + vy_q;
    nx       = clamp12(nx_raw);
    ny       = clamp12(ny_raw);
    nx_e     = {{2{nx[11]}}, nx};
    ny_e     = {{2{ny[11]}}, ny};
    screen_y = SCR_H - ny_e;
    vy_next  = vy_q - GRAV;
    in_tgt   = (screen_y >= T_YT) && (screen_y <= T_YB) && (nx_e >= T_XL) && (nx_e <= T_XR);
    in_wall  = (screen_y >= W_Y) && (nx_e >= W_XL) && (nx_e <= W_XR);
    in_floor = (ny_e <= FLOOR) || (nx_e < 14'sd0) || (nx_e >= SCR_W);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    outcome_d    = outcome_q;
    hit_target_d = 1'b0;
    hit_wall_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        x_d       = SX;
        y_d       = SY;
        outcome_d = 2'd0;
        if (ctl.enable) begin
          vx_d    = vx_launch;
          vy_d    = VY_INIT;
          state_d = S_ASCEND;
        end
      end

      S_ASCEND, S_DESCEND: begin
        if (!ctl.enable) begin
          // Abort wins over a coincident tick: no result is reported.
          state_d   = S_IDLE;
          cnt_d     = '0;
          x_d       = SX;
          y_d       = SY;
          outcome_d = 2'd0;
        end else if (tick) begin
          cnt_d = '0;
          x_d   = nx;
          y_d   = ny;
          vy_d  = vy_next;
          if (state_q == S_ASCEND && vy_next <= 14'sd0) state_d = S_DESCEND;
          if (in_tgt || in_wall || in_floor) begin
            state_d = S_RESULT;
            x_d     = SX;
            y_d     = SY;
            if (in_tgt) begin
              outcome_d    = 2'd1;
              hit_target_d = 1'b1;
            end else if (in_wall) begin
              outcome_d  = 2'd2;
              hit_wall_d = 1'b1;
            end else begin
              outcome_d = 2'd3;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESULT: begin
        cnt_d = '0;
        // Leaving on enable low is the only way out, so a held request never relaunches.
        if (!ctl.enable) begin
          state_d   = S_IDLE;
          outcome_d = 2'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      x_q          <= SX;
      y_q          <= SY;
      vx_q         <= '0;
      vy_q         <= '0;
      outcome_q    <= 2'd0;
      hit_target_q <= 1'b0;
      hit_wall_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      outcome_q    <= outcome_d;
      hit_target_q <= hit_target_d;
      hit_wall_q   <= hit_wall_d;
    end
  end

  assign ctl.x_pos      = x_q;
  assign ctl.y_pos      = y_q;
  assign ctl.busy       = (state_q == S_ASCEND) || (state_q == S_DESCEND);
  assign ctl.throw_done = (state_q == S_RESULT);
  assign ctl.outcome    = outcome_q;
  assign ctl.hit_target = hit_target_q;
  assign ctl.hit_wall   = hit_wall_q;

endmodule

// File: tb/tb_throw_traj_ctl.sv
// tb/tb_throw_traj_ctl.sv - self-checking bench for throw_traj_ctl
module tb_throw_traj_ctl;
  localparam int TD = 4;

  typedef struct {
    int sx; int sy; int dir; int v0;
    int txl; int txr; int tyt; int tyb;
  } cfg_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses_lob = 0;
  int   exp_x[$];
  int   exp_y[$];
  int   exp_out;
  cfg_t c_lob, c_tgt, c_wall, c_prio;

  throw_traj_ctl_if if_lob ();
  throw_traj_ctl_if if_tgt ();
  throw_traj_ctl_if if_wall ();
  throw_traj_ctl_if if_prio ();

  throw_traj_ctl #(.TICK_DIV(TD), .V0(5)) u_lob (.clk(clk), .rst(rst), .ctl(if_lob.slave));
  throw_traj_ctl #(.TICK_DIV(TD), .START_X(800), .START_Y(300), .V0(0))
    u_tgt (.clk(clk), .rst(rst), .ctl(if_tgt.slave));
  throw_traj_ctl #(.TICK_DIV(TD), .START_X(700), .DIR(-1), .V0(5))
    u_wall (.clk(clk), .rst(rst), .ctl(if_wall.slave));
  throw_traj_ctl #(.TICK_DIV(TD), .START_X(700), .DIR(-1), .V0(5),
                   .TGT_XL(500), .TGT_XR(540), .TGT_YT(380), .TGT_YB(420))
    u_prio (.clk(clk), .rst(rst), .ctl(if_prio.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_lob.hit_target || if_lob.hit_wall) pulses_lob++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int wind_eff_of(input int w);
    if (w > 50) return -(5 + ((w - 50) / 8));
    if (w < 50) return 5 + ((50 - w) / 8);
    return 0;
  endfunction

  function automatic int clamp12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference trajectory: one entry per tick until the first hit.
  function automatic void predict(input cfg_t c, input int frc, input int wind);
    int x, y, vx, vy, sy;
    x = c.sx; y = c.sy; vy = c.v0;
    vx = c.dir * ((frc * 18) / 64) + wind_eff_of(wind);
    exp_x.delete(); exp_y.delete(); exp_out = 0;
    while (exp_out == 0 && exp_x.size() < 200) begin
      x = clamp12(x + vx);
      y = clamp12(y + vy);
      vy = vy - 1;
      exp_x.push_back(x); exp_y.push_back(y);
      sy = 768 - y;
      if (sy >= c.tyt && sy <= c.tyb && x >= c.txl && x <= c.txr) exp_out = 1;
      else if (sy >= 241 - 15 && x >= 490 - 15 && x <= 534 + 15) exp_out = 2;
      else if (y <= 190 || x < 0 || x >= 1024) exp_out = 3;
    end
  endfunction

  task automatic test_reset();
    n_checks++;
    if (if_lob.x_pos !== 12'sd140 || if_lob.y_pos !== 12'sd350) begin
      n_fail++; $display("FAIL reset_pos: got x=%0d y=%0d want x=140 y=350", if_lob.x_pos, if_lob.y_pos);
    end
    n_checks++;
    if ({if_lob.busy, if_lob.hit_target, if_lob.hit_wall, if_lob.outcome, if_lob.throw_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_status: got busy=%0b ht=%0b hw=%0b out=%0d done=%0b want all 0",
                         if_lob.busy, if_lob.hit_target, if_lob.hit_wall, if_lob.outcome, if_lob.throw_done);
    end
    n_checks++;
    if (if_tgt.x_pos !== 12'sd800 || if_tgt.y_pos !== 12'sd300) begin
      n_fail++; $display("FAIL reset_pos_tgt: got x=%0d y=%0d want x=800 y=300", if_tgt.x_pos, if_tgt.y_pos);
    end
  endtask

  task automatic test_lob();
    int lob_y[5] = '{355, 359, 362, 364, 365};
    predict(c_lob, 0, 50);
    if_lob.throw_force = 10'd0; if_lob.wind_force = 7'd50; if_lob.enable = 1'b1;
    cyc(1);
    n_checks++;
    if (if_lob.busy !== 1'b1) begin n_fail++; $display("FAIL lob_busy: got %0b want 1", if_lob.busy); end
    cyc(TD - 1);
    n_checks++;
    if (if_lob.y_pos !== 12'sd350) begin n_fail++; $display("FAIL lob_pre_tick: got y=%0d want 350", if_lob.y_pos); end
    cyc(1);
    for (int k = 0; k < exp_x.size() - 1; k++) begin
      if (k > 0) cyc(TD);
      n_checks++;
      if (if_lob.x_pos !== 12'sd140 || if_lob.y_pos !== exp_y[k] || if_lob.busy !== 1'b1) begin
        n_fail++; $display("FAIL lob_tick[%0d]: got x=%0d y=%0d busy=%0b want x=140 y=%0d busy=1",
                           k, if_lob.x_pos, if_lob.y_pos, if_lob.busy, exp_y[k]);
      end
      if (k < 5) begin
        n_checks++;
        if (if_lob.y_pos !== lob_y[k]) begin
          n_fail++; $display("FAIL lob_y_seq[%0d]: got %0d want %0d", k, if_lob.y_pos, lob_y[k]);
        end
      end
    end
    cyc(TD);
    n_checks++;
    if (if_lob.outcome !== 2'd3 || if_lob.throw_done !== 1'b1 || if_lob.busy !== 1'b0 ||
        if_lob.x_pos !== 12'sd140 || if_lob.y_pos !== 12'sd350 || if_lob.hit_target || if_lob.hit_wall) begin
      n_fail++; $display("FAIL lob_end: got out=%0d done=%0b busy=%0b x=%0d y=%0d ht=%0b hw=%0b want 3 1 0 140 350 0 0",
                         if_lob.outcome, if_lob.throw_done, if_lob.busy, if_lob.x_pos, if_lob.y_pos,
                         if_lob.hit_target, if_lob.hit_wall);
    end
  endtask

  task automatic test_result_hold();
    int p0 = pulses_lob;
    cyc(10 * TD);
    n_checks++;
    if (if_lob.throw_done !== 1'b1 || if_lob.busy !== 1'b0 || if_lob.outcome !== 2'd3 || pulses_lob !== p0) begin
      n_fail++; $display("FAIL result_hold: got done=%0b busy=%0b out=%0d pulses=%0d want 1 0 3 %0d",
                         if_lob.throw_done, if_lob.busy, if_lob.outcome, pulses_lob, p0);
    end
    if_lob.enable = 1'b0;
    cyc(1);
    n_checks++;
    if (if_lob.throw_done !== 1'b0 || if_lob.outcome !== 2'd0) begin
      n_fail++; $display("FAIL rearm_idle: got done=%0b out=%0d want 0 0", if_lob.throw_done, if_lob.outcome);
    end
    if_lob.enable = 1'b1;
    cyc(1);
    n_checks++;
    if (if_lob.busy !== 1'b1) begin n_fail++; $display("FAIL rearm_launch: got busy=%0b want 1", if_lob.busy); end
    if_lob.enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_wind();
    int winds[3] = '{0, 127, 50};
    int incs[3]  = '{11, -14, 0};
    for (int i = 0; i < 3; i++) begin
      if_lob.throw_force = 10'd0; if_lob.wind_force = 7'(winds[i]); if_lob.enable = 1'b1;
      cyc(1 + TD);
      n_checks++;
      if (if_lob.x_pos !== 140 + incs[i]) begin
        n_fail++; $display("FAIL wind[%0d]: got x=%0d want %0d", winds[i], if_lob.x_pos, 140 + incs[i]);
      end
      cyc(TD);
      n_checks++;
      if (if_lob.x_pos !== 140 + 2 * incs[i]) begin
        n_fail++; $display("FAIL wind2[%0d]: got x=%0d want %0d", winds[i], if_lob.x_pos, 140 + 2 * incs[i]);
      end
      if_lob.enable = 1'b0;
      cyc(1);
    end
    if_lob.wind_force = 7'd50;
  endtask

  task automatic test_abort();
    int p0;
    if_lob.throw_force = 10'd0; if_lob.enable = 1'b1;
    cyc(1 + 2 * TD);
    n_checks++;
    if (if_lob.y_pos !== 12'sd359) begin n_fail++; $display("FAIL abort_pre: got y=%0d want 359", if_lob.y_pos); end
    p0 = pulses_lob;
    if_lob.enable = 1'b0;
    cyc(1);
    n_checks++;
    if (if_lob.busy !== 1'b0 || if_lob.outcome !== 2'd0 || if_lob.throw_done !== 1'b0 ||
        if_lob.x_pos !== 12'sd140 || if_lob.y_pos !== 12'sd350) begin
      n_fail++; $display("FAIL abort_idle: got busy=%0b out=%0d done=%0b x=%0d y=%0d want 0 0 0 140 350",
                         if_lob.busy, if_lob.outcome, if_lob.throw_done, if_lob.x_pos, if_lob.y_pos);
    end
    cyc(2 * TD);
    n_checks++;
    if (pulses_lob !== p0 || if_lob.y_pos !== 12'sd350) begin
      n_fail++; $display("FAIL abort_quiet: got pulses=%0d y=%0d want %0d 350", pulses_lob, if_lob.y_pos, p0);
    end
  endtask

  task automatic test_target();
    predict(c_tgt, 128, 50);
    if_tgt.throw_force = 10'd128; if_tgt.wind_force = 7'd50; if_tgt.enable = 1'b1;
    cyc(1 + TD);
    n_checks++;
    if (if_tgt.x_pos !== 12'sd836 || if_tgt.x_pos !== exp_x[0] || if_tgt.busy !== 1'b1) begin
      n_fail++; $display("FAIL tgt_tick1: got x=%0d busy=%0b want x=836 busy=1", if_tgt.x_pos, if_tgt.busy);
    end
    cyc(TD);
    n_checks++;
    if (if_tgt.hit_target !== 1'b1 || if_tgt.hit_wall !== 1'b0 || if_tgt.outcome !== 2'd1 ||
        if_tgt.throw_done !== 1'b1 || if_tgt.x_pos !== 12'sd800 || if_tgt.outcome !== exp_out) begin
      n_fail++; $display("FAIL tgt_hit: got ht=%0b hw=%0b out=%0d done=%0b x=%0d want 1 0 1 1 800",
                         if_tgt.hit_target, if_tgt.hit_wall, if_tgt.outcome, if_tgt.throw_done, if_tgt.x_pos);
    end
    cyc(1);
    n_checks++;
    if (if_tgt.hit_target !== 1'b0 || if_tgt.outcome !== 2'd1 || if_tgt.throw_done !== 1'b1) begin
      n_fail++; $display("FAIL tgt_pulse_len: got ht=%0b out=%0d done=%0b want 0 1 1",
                         if_tgt.hit_target, if_tgt.outcome, if_tgt.throw_done);
    end
    if_tgt.enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_wall();
    predict(c_wall, 128, 50);
    if_wall.throw_force = 10'd128; if_wall.wind_force = 7'd50; if_wall.enable = 1'b1;
    cyc(1);
    for (int k = 0; k < exp_x.size() - 1; k++) begin
      cyc(TD);
      n_checks++;
      if (if_wall.x_pos !== exp_x[k] || if_wall.y_pos !== exp_y[k]) begin
        n_fail++; $display("FAIL wall_tick[%0d]: got x=%0d y=%0d want x=%0d y=%0d",
                           k, if_wall.x_pos, if_wall.y_pos, exp_x[k], exp_y[k]);
      end
    end
    cyc(TD);
    n_checks++;
    if (if_wall.hit_wall !== 1'b1 || if_wall.hit_target !== 1'b0 || if_wall.outcome !== 2'd2) begin
      n_fail++; $display("FAIL wall_hit: got hw=%0b ht=%0b out=%0d want 1 0 2",
                         if_wall.hit_wall, if_wall.hit_target, if_wall.outcome);
    end
    cyc(1);
    n_checks++;
    if (if_wall.hit_wall !== 1'b0 || if_wall.outcome !== 2'd2) begin
      n_fail++; $display("FAIL wall_pulse_len: got hw=%0b out=%0d want 0 2", if_wall.hit_wall, if_wall.outcome);
    end
    if_wall.enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_priority();
    predict(c_prio, 128, 50);
    if_prio.throw_force = 10'd128; if_prio.wind_force = 7'd50; if_prio.enable = 1'b1;
    cyc(1 + TD * exp_x.size());
    n_checks++;
    if (if_prio.hit_target !== 1'b1 || if_prio.hit_wall !== 1'b0 || if_prio.outcome !== 2'd1) begin
      n_fail++; $display("FAIL prio_hit: got ht=%0b hw=%0b out=%0d want 1 0 1",
                         if_prio.hit_target, if_prio.hit_wall, if_prio.outcome);
    end
    if_prio.enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_random();
    int frc, wind;
    for (int it = 0; it < 8; it++) begin
      frc  = $urandom_range(0, 1023);
      wind = $urandom_range(0, 127);
      predict(c_lob, frc, wind);
      if_lob.throw_force = 10'(frc); if_lob.wind_force = 7'(wind); if_lob.enable = 1'b1;
      cyc(1);
      for (int k = 0; k < exp_x.size() - 1; k++) begin
        cyc(TD);
        n_checks++;
        if (if_lob.x_pos !== exp_x[k] || if_lob.y_pos !== exp_y[k] || if_lob.busy !== 1'b1) begin
          n_fail++; $display("FAIL rand_pos f=%0d w=%0d t=%0d: got x=%0d y=%0d busy=%0b want x=%0d y=%0d busy=1",
                             frc, wind, k, if_lob.x_pos, if_lob.y_pos, if_lob.busy, exp_x[k], exp_y[k]);
        end
      end
      cyc(TD);
      n_checks++;
      if (if_lob.outcome !== exp_out || if_lob.throw_done !== 1'b1 ||
          if_lob.hit_target !== (exp_out == 1) || if_lob.hit_wall !== (exp_out == 2)) begin
        n_fail++; $display("FAIL rand_end f=%0d w=%0d: got out=%0d done=%0b ht=%0b hw=%0b want out=%0d done=1",
                           frc, wind, if_lob.outcome, if_lob.throw_done, if_lob.hit_target, if_lob.hit_wall, exp_out);
      end
      if_lob.enable = 1'b0;
      cyc(1);
    end
    if_lob.wind_force = 7'd50;
  endtask

  task automatic test_reset_mid();
    int p0;
    if_lob.throw_force = 10'd0; if_lob.enable = 1'b1;
    cyc(1 + 8 * TD);
    p0 = pulses_lob;
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (if_lob.busy !== 1'b0 || if_lob.x_pos !== 12'sd140 || if_lob.y_pos !== 12'sd350 ||
        if_lob.outcome !== 2'd0 || if_lob.throw_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got busy=%0b x=%0d y=%0d out=%0d done=%0b want 0 140 350 0 0",
                         if_lob.busy, if_lob.x_pos, if_lob.y_pos, if_lob.outcome, if_lob.throw_done);
    end
    if_lob.enable = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    n_checks++;
    if (if_lob.busy !== 1'b0 || if_lob.throw_done !== 1'b0 || pulses_lob !== p0) begin
      n_fail++; $display("FAIL rst_idle: got busy=%0b done=%0b pulses=%0d want 0 0 %0d",
                         if_lob.busy, if_lob.throw_done, pulses_lob, p0);
    end
    if_lob.enable = 1'b1;
    cyc(1);
    n_checks++;
    if (if_lob.busy !== 1'b1) begin n_fail++; $display("FAIL rst_relaunch: got busy=%0b want 1", if_lob.busy); end
    if_lob.enable = 1'b0;
    cyc(1);
  endtask

  initial begin
    c_lob  = '{140, 350,  1, 5, 867, 1024, 427, 525};
    c_tgt  = '{800, 300,  1, 0, 867, 1024, 427, 525};
    c_wall = '{700, 350, -1, 5, 867, 1024, 427, 525};
    c_prio = '{700, 350, -1, 5, 500,  540, 380, 420};
    rst = 1'b1;
    if_lob.enable  = 1'b0; if_lob.throw_force  = '0; if_lob.wind_force  = 7'd50;
    if_tgt.enable  = 1'b0; if_tgt.throw_force  = '0; if_tgt.wind_force  = 7'd50;
    if_wall.enable = 1'b0; if_wall.throw_force = '0; if_wall.wind_force = 7'd50;
    if_prio.enable = 1'b0; if_prio.throw_force = '0; if_prio.wind_force = 7'd50;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    test_reset();
    test_lob();
    test_result_hold();
    test_wind();
    test_abort();
    test_target();
    test_wall();
    test_priority();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/throw_traj_ctl.md
# throw_traj_ctl

Parametrised projectile controller for the throw phase of the game. It is the generalised successor of the per-player throw controllers. One instance per thrower is set through parameters: launch point, throw direction, physics constants, target box and wall box. Flight is integrated incrementally (velocity add per tick, no multipliers in the loop), and the block reports a registered outcome (target, wall, floor/out) to the game FSM.

## Interface
Parameters:
- TICK_DIV, 1_300_000: clk cycles per physics tick (≥2).
- START_X, 140 / START_Y, 350: launch point, world coords (y up).
- DIR, 1: +1 throws right, -1 throws left.
- V0, 27: initial vertical velocity, px/tick.
- GRAVITY, 1: vertical decrement per tick.
- FORCE_GAIN, 18 / FORCE_SHIFT, 6: vx_force = (throw_force*FORCE_GAIN) >> FORCE_SHIFT.
- SCREEN_W, 1024 / SCREEN_H, 768: screen size; screen_y = SCREEN_H - y.
- TGT_XL, 867 / TGT_XR, 1024 / TGT_YT, 427 / TGT_YB, 525: target box, screen coords, inclusive.
- WALL_XL, 490 / WALL_XR, 534 / WALL_TOP, 241 / WALL_MARGIN, 15: wall box, screen coords.
- FLOOR_Y, 190: world y at or below which flight ends.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  level throw request from game FSM.
- throw_force  in  10  unsigned charge value.
- wind_force  in  7  unsigned wind, 50 = calm.
- x_pos, y_pos  out  12 signed  projectile world position.
- busy  out  1  high in ASCEND/DESCEND.
- hit_target  out  1  one-cycle pulse on target hit.
- hit_wall  out  1  one-cycle pulse on wall hit.
- outcome  out  2  0 none, 1 target, 2 wall, 3 floor/out.
- throw_done  out  1  high while in RESULT.

## Operation
- States: IDLE, ASCEND, DESCEND, RESULT.
- IDLE: x/y = START, tick counter held 0. When enable=1, latch vx = DIR*vx_force + wind_eff and set vy = V0, then go to ASCEND. outcome is cleared to 0.
- wind_eff: if wind>50, -(5 + ((wind-50)>>3)); if wind<50, 5 + ((50-wind)>>3); if wind=50, 0. Wind is not multiplied by DIR.
- On each tick in ASCEND/DESCEND: x += vx, y += vy, vy -= GRAVITY. Arithmetic is 14-bit signed; x/y are clamped to [-2048, 2047].
- ASCEND→DESCEND on the tick where the updated vy ≤ 0.
- Checks run on the newly computed position, on the same tick edge, in priority order:
  - Target: screen_y in [TGT_YT, TGT_YB] and x in [TGT_XL, TGT_XR]. Result outcome=1.
  - Wall: screen_y ≥ WALL_TOP-WALL_MARGIN and x in [WALL_XL-WALL_MARGIN, WALL_XR+WALL_MARGIN]. Result outcome=2.
  - Floor/out: y ≤ FLOOR_Y, or x < 0, or x ≥ SCREEN_W. Result outcome=3.
  - Any hit moves the FSM to RESULT on that edge.
- RESULT: throw_done=1, outcome held, x/y = START. Return to IDLE when enable=0.
- Abort: enable=0 during ASCEND/DESCEND goes to IDLE next edge with no pulse and outcome=0.

## Timing
- Reset values: state IDLE, x_pos=START_X, y_pos=START_Y, busy=0, hit_target=0, hit_wall=0, outcome=0, throw_done=0, tick counter 0.
- Launch: enable sampled high in IDLE, busy=1 from the next cycle. The first tick fires TICK_DIV cycles after entering ASCEND, then every TICK_DIV cycles.
- Position outputs are registered and change only on tick edges while in flight.
- On a hit edge, hit_target/hit_wall are 1 during the first RESULT cycle only. throw_done and outcome are valid in that same cycle.
- enable remaining high in RESULT never relaunches. A new throw needs enable low for ≥1 cycle.
- Async rst mid-flight: all outputs return to reset values immediately and no pulse is emitted.
- A launch never triggers a hit at START itself. Checks apply only on tick updates.

## Test plan
- Vertical lob: TICK_DIV=4, V0=5, throw_force=0, wind=50, DIR=1. Required y sequence 355, 359, 362, 364, 365, then DESCEND; x stays 140. Flight ends with outcome=3 at the first y ≤ 190; throw_done=1 and x/y=140/350.
- Target hit: START_X=800, START_Y=300, V0=0, throw_force=128 (vx=36), wind=50. Required: x=836, then 872 on the 2nd tick with screen_y in range → hit_target one cycle, outcome=1, hit_wall=0.
- Wall hit: DIR=-1 instance thrown into the wall box. Required: hit_wall pulse, outcome=2. A simultaneous target overlap must still give outcome=1 (priority check).
- Wind: wind=0 → wind_eff=+11; wind=127 → wind_eff=-14; wind=50 → 0. Check via x increment per tick with throw_force=0.
- Abort and re-arm: drop enable after 2 ticks → IDLE next cycle with no pulses. Hold enable high in RESULT for 10 ticks → no relaunch; drop then raise → new flight.
- Reset mid-flight: assert rst between clk edges during DESCEND. Required: outputs go to reset values asynchronously; after release the block is in IDLE.
